// File: rtl/fb_swap_scheduler_pkg.sv
// rtl/fb_swap_scheduler_pkg.sv - shared types and defaults for the double-buffer scheduler
package fb_swap_scheduler_pkg;

  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } screenXY;

  typedef logic [2:0] color_t;

  typedef enum logic [1:0] {IDLE, CLEAR, RENDER, WAIT_SWAP} sched_state_t;

  function automatic logic in_screen(input screenXY p, input int h_res, input int v_res);
    return (int'(p.x) < h_res) && (int'(p.y) < v_res);
  endfunction

endpackage

// File: rtl/fb_swap_scheduler_clear.sv
// rtl/fb_swap_scheduler_clear.sv - raster scanner that walks every visible pixel once per start
// coords is the pixel emitted on the next firing edge; last flags that the final pixel went out.
module fb_clear_scanner
  import fb_swap_scheduler_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic    Clk,
  input  logic    Reset,
  input  logic    start,
  output screenXY coords,
  output logic    valid,
  output logic    last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  screenXY coords_q, coords_d;
  logic    valid_q, valid_d;
  logic    last_q, last_d;
  logic    fire, at_end;

  // Counter rests at (0,0) between passes, so start needs no explicit load.
  always_comb begin
    fire     = start | valid_q;
    at_end   = (coords_q.x == X_LAST) && (coords_q.y == Y_LAST);
    coords_d = coords_q;
    valid_d  = valid_q;
    last_d   = 1'b0;
    if (fire) begin
      last_d  = at_end;
      valid_d = !at_end;
      if (coords_q.x == X_LAST) begin
        coords_d.x = '0;
        coords_d.y = at_end ? '0 : coords_q.y + 1'b1;
      end else begin
        coords_d.x = coords_q.x + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      coords_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      coords_q <= coords_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign coords = coords_q;
  assign valid  = valid_q;
  assign last   = last_q;

endmodule

// File: rtl/fb_swap_scheduler.sv
// rtl/fb_swap_scheduler.sv - frame sequencer: clear, render, wait for vblank, swap
module fb_swap_scheduler
  import fb_swap_scheduler_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int DROP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              new_frame,
  input  logic              clear_en,
  input  color_t            clear_color,
  input  screenXY           render_coords,
  input  color_t            render_color,
  input  logic              render_we,
  input  logic              render_done,
  output logic              render_start,
  output logic              render_ack,
  output screenXY           fb_coords,
  output color_t            fb_color,
  output logic              fb_we,
  output logic              front_sel,
  output logic              busy,
  output logic [DROP_W-1:0] frames_dropped
);

  sched_state_t      state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              fb_we_q, fb_we_d;
  screenXY           fb_coords_q, fb_coords_d;
  color_t            fb_color_q, fb_color_d;
  logic              render_start_q, render_start_d;
  logic              render_ack_q, render_ack_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic    swap, scan_start, scan_valid, scan_last;
  screenXY scan_coords;

  fb_clear_scanner #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_scanner (
    .Clk   (Clk),
    .Reset (Reset),
    .start (scan_start),
    .coords(scan_coords),
    .valid (scan_valid),
    .last  (scan_last)
  );

  always_comb begin
    state_d        = state_q;
    front_sel_d    = front_sel_q;
    drop_d         = drop_q;
    fb_we_d        = 1'b0;
    fb_coords_d    = fb_coords_q;
    fb_color_d     = fb_color_q;
    render_ack_d   = 1'b0;
    swap           = 1'b0;

    case (state_q)
      IDLE:      state_d = clear_en ? CLEAR : RENDER;
      CLEAR:     if (scan_last) state_d = RENDER;
      RENDER: begin
        if (render_done) begin
          if (new_frame) swap = 1'b1;
          else           state_d = WAIT_SWAP;
        end
      end
      WAIT_SWAP: if (new_frame) swap = 1'b1;
      default:   state_d = IDLE;
    endcase

    if (swap) begin
      front_sel_d  = ~front_sel_q;
      render_ack_d = 1'b1;
      state_d      = clear_en ? CLEAR : RENDER;
    end

    // A vblank while still drawing is a missed frame.
    if (new_frame && !swap && (state_q == CLEAR || state_q == RENDER) && (drop_q != '1))
      drop_d = drop_q + 1'b1;

    scan_start     = (state_d == CLEAR) && (state_q != CLEAR);
    render_start_d = (state_d == RENDER) && ((state_q != RENDER) || swap);
    busy_d         = (state_d == CLEAR) || (state_d == RENDER);

    // The clear engine owns the write port whenever it is emitting pixels.
    if (scan_start || (state_q == CLEAR && scan_valid)) begin
      fb_we_d     = 1'b1;
      fb_coords_d = scan_coords;
      fb_color_d  = clear_color;
    end else if (state_q == RENDER) begin
      fb_we_d     = render_we && in_screen(render_coords, H_RES, V_RES);
      fb_coords_d = render_coords;
      fb_color_d  = render_color;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      front_sel_q    <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_coords_q    <= '0;
      fb_color_q     <= '0;
      render_start_q <= 1'b0;
      render_ack_q   <= 1'b0;
      busy_q         <= 1'b0;
      drop_q         <= '0;
    end else begin
      state_q        <= state_d;
      front_sel_q    <= front_sel_d;
      fb_we_q        <= fb_we_d;
      fb_coords_q    <= fb_coords_d;
      fb_color_q     <= fb_color_d;
      render_start_q <= render_start_d;
      render_ack_q   <= render_ack_d;
      busy_q         <= busy_d;
      drop_q         <= drop_d;
    end
  end

  assign render_start   = render_start_q;
  assign render_ack     = render_ack_q;
  assign fb_coords      = fb_coords_q;
  assign fb_color       = fb_color_q;
  assign fb_we          = fb_we_q;
  assign front_sel      = front_sel_q;
  assign busy           = busy_q;
  assign frames_dropped = drop_q;

endmodule
